uart_time_rx: RTL and testbench
===============================

# uart_time_rx

Receive-side companion to the alarm-clock system's UART transmitter. It listens on the serial line driven by the Nios II `uart_txd`, deserialises 8N1 frames and parses ASCII time reports of the form `HH:MM:SS` followed by CR. Each valid line becomes a packed-BCD time value with a one-cycle strobe. It is used on the monitor/test board and in system-level benches to check what the processor reports, with optional local seven-segment mirroring.

## Interface

Parameters:
- `CLK_HZ`, 50000000: clock frequency in Hz.
- `BAUD`, 115200: line rate. `CLKS_PER_BIT = CLK_HZ/BAUD`, integer-truncated (434 at defaults). Must be ≥ 8.

Ports:
- `clk_clk`  in  1  single clock; all logic is on its rising edge.
- `reset_reset`  in  1  synchronous, active-high reset.
- `uart_rxd`  in  1  serial input, idle high, asynchronous to `clk_clk`.
- `rx_byte`  out  8  last received byte.
- `rx_byte_valid`  out  1  one-cycle pulse when `rx_byte` updates.
- `hours`, `minutes`, `seconds`  out  8 each  packed BCD (high nibble = tens), held until the next valid line.
- `time_valid`  out  1  one-cycle pulse when the BCD outputs update.
- `frame_err`  out  1  one-cycle pulse on a bad stop bit.
- `parse_err`  out  1  one-cycle pulse on a malformed line.
- `segment1_export` … `segment6_export`  out  8 each  present only with `UART_TIME_RX_SEG_EN`; see Configuration.

## Operation

Input synchroniser:
- Two flops on `uart_rxd`, reset to 1. All logic uses the synchronised bit `rxs`.

Bit FSM, states IDLE, START, DATA, STOP:
- IDLE: when `rxs` = 0, load the counter with `CLKS_PER_BIT/2 - 1` and go to START.
- START: at counter expiry, if `rxs` = 0, reload `CLKS_PER_BIT - 1`, clear the bit index and go to DATA. If `rxs` = 1, treat it as a glitch and return to IDLE with no output.
- DATA: at each expiry, shift `rxs` in LSB-first and reload the counter. After the 8th bit, go to STOP.
- STOP: at expiry, if `rxs` = 1, pulse `rx_byte_valid` and update `rx_byte`. If `rxs` = 0, pulse `frame_err` and discard the byte. In both cases go to IDLE.
- After a framing error, IDLE will not accept a new start until `rxs` has been high for at least one cycle (break protection).

Line parser (position counter 0..8):
- Positions 0,1,3,4,6,7 expect ASCII '0'–'9' (0x30–0x39). Digits are stored as nibbles.
- Positions 2 and 5 expect ':' (0x3A).
- Position 8 expects CR (0x0D).
- LF (0x0A) received at position 0 is ignored and the counter does not advance.
- On CR at position 8, range-check: hours ≤ 0x23, minutes ≤ 0x59, seconds ≤ 0x59.
  - Pass: update `hours`/`minutes`/`seconds` and pulse `time_valid`.
  - Fail: pulse `parse_err`.
  - Either way, the position returns to 0.
- Any unexpected byte pulses `parse_err` and returns to position 0. A CR received early is not re-examined as the start of a new line.
- A `frame_err` forces the parser to position 0 with no `parse_err`.

Reset (any cycle, including mid-frame or mid-line):
- FSM goes to IDLE, parser to position 0, synchroniser to 1.
- `rx_byte` = 0x00; `hours`/`minutes`/`seconds` = 0x00.
- All pulse outputs = 0; segments show "000000".

## Timing

- Let t0 be the first cycle in which `rxs` = 0. The pin-to-`rxs` latency is 2 cycles.
- Start-bit check at t0 + `CLKS_PER_BIT/2`.
- Data bit n (0..7) sampled at t0 + `CLKS_PER_BIT/2` + (n+1)·`CLKS_PER_BIT`.
- Stop bit sampled at t0 + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT`. `rx_byte_valid` or `frame_err` is high in the following cycle.
- Parser is registered: `time_valid` or `parse_err` asserts exactly 1 cycle after the `rx_byte_valid` of the deciding byte. The BCD outputs change in that same cycle.
- Pulses never last more than 1 cycle. `frame_err` and `rx_byte_valid` are mutually exclusive. `time_valid` and `parse_err` are mutually exclusive.
- Back-to-back frames with no idle gap are received without loss, since the FSM returns to IDLE during the stop bit.

## Configuration

- `UART_TIME_RX_SEG_EN` defined:
  - `segment1_export`…`segment6_export` are present. segment1 is the seconds units digit and segment6 is the hours tens digit.
  - Encoding is active-low, bit0 = a … bit6 = g, bit7 = dp held at 1 (off).
  - Segment outputs are registered from the BCD outputs, so they change 1 cycle after `time_valid`.
- Undefined: the segment ports and decoder logic are absent; everything else is unchanged.

## Test plan

- Send "12:34:56" CR at 115200 baud → one `time_valid` pulse; hours = 0x12, minutes = 0x34, seconds = 0x56. With the macro, segment1 = 0x82 ('6') and segment6 = 0xF9 ('1').
- Send "24:00:00" CR → `parse_err` pulse 1 cycle after the CR byte; BCD outputs remain 0x12/0x34/0x56.
- Send the byte 0x31 with the stop bit driven low → `frame_err` pulse, no `rx_byte_valid`. Then "07:08:09" CR → hours = 0x07, minutes = 0x08, seconds = 0x09.
- Drive a 100-cycle low glitch on `uart_rxd` (less than `CLKS_PER_BIT/2`) → no pulses on any output; a following valid line decodes correctly.
- Send "LF 23:59:59 CR LF 00:00:00 CR" back-to-back → two `time_valid` pulses with values 0x235959 then 0x000000.
- Assert `reset_reset` for 1 cycle midway through the DATA bits of the 4th character → all outputs at reset values; the rest of that line produces no `time_valid`; the next complete line decodes correctly.

Source files
------------

// File: rtl/uart_time_rx_if.sv
// Output bundle of uart_time_rx: serial input, received byte, decoded BCD time,
// event pulses and the bit-FSM state for observation.
interface uart_time_rx_if;
    // No backpressure anywhere: every *_valid / *_err strobe is a single-cycle
    // event and its data stays stable until the next strobe of the same kind.
    logic       uart_rxd;
    logic [7:0] rx_byte;
    logic       rx_byte_valid;
    logic [7:0] hours;
    logic [7:0] minutes;
    logic [7:0] seconds;
    logic       time_valid;
    logic       frame_err;
    logic       parse_err;
    logic [1:0] rx_state;

    modport master (
        output uart_rxd,
        input  rx_byte, rx_byte_valid, hours, minutes, seconds,
        input  time_valid, frame_err, parse_err, rx_state
    );

    modport slave (
        input  uart_rxd,
        output rx_byte, rx_byte_valid, hours, minutes, seconds,
        output time_valid, frame_err, parse_err, rx_state
    );
endinterface

// File: rtl/uart_time_rx.sv
// 8N1 UART receiver that parses "HH:MM:SS<CR>" lines into packed BCD time.
// Define UART_TIME_RX_SEG_EN to add six registered active-low seven-segment outputs.
module uart_time_rx #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200
) (
    input  logic           clk_clk,
    input  logic           reset_reset,
    uart_time_rx_if.slave  io
`ifdef UART_TIME_RX_SEG_EN
    ,
    output logic [7:0]     segment1_export,
    output logic [7:0]     segment2_export,
    output logic [7:0]     segment3_export,
    output logic [7:0]     segment4_export,
    output logic [7:0]     segment5_export,
    output logic [7:0]     segment6_export
`endif
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_COLON = 8'h3A;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // ---------------------------------------------------------------
    // Input synchroniser
    // ---------------------------------------------------------------
    logic [1:0] sync;
    logic       rxs;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], io.uart_rxd};
        end
    end

    assign rxs = sync[1];

    // ---------------------------------------------------------------
    // Bit FSM
    // ---------------------------------------------------------------
    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [7:0]    rx_byte_r;
    logic          byte_vld_r;
    logic          frame_err_r;
    logic          need_high;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            bit_idx     <= 3'd0;
            shreg       <= 8'h00;
            rx_byte_r   <= 8'h00;
            byte_vld_r  <= 1'b0;
            frame_err_r <= 1'b0;
            need_high   <= 1'b0;
        end else begin
            byte_vld_r  <= 1'b0;
            frame_err_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    // After a bad stop bit the line must return high before a new start counts.
                    if (need_high) begin
                        if (rxs) need_high <= 1'b0;
                    end else if (!rxs) begin
                        cnt   <= HALF_LOAD;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (cnt == '0) begin
                        if (!rxs) begin
                            cnt     <= FULL_LOAD;
                            bit_idx <= 3'd0;
                            state   <= S_DATA;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == '0) begin
                        shreg <= {rxs, shreg[7:1]};
                        cnt   <= FULL_LOAD;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_STOP: begin
                    // Returning to IDLE mid stop bit leaves room for back-to-back frames.
                    if (cnt == '0) begin
                        if (rxs) begin
                            rx_byte_r  <= shreg;
                            byte_vld_r <= 1'b1;
                        end else begin
                            frame_err_r <= 1'b1;
                            need_high   <= 1'b1;
                        end
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Line parser
    // ---------------------------------------------------------------
    logic [3:0] pos;
    logic [3:0] dig [6];
    logic [2:0] didx;
    logic [7:0] hours_r, minutes_r, seconds_r;
    logic       tv_r, perr_r;
    logic       is_digit, range_ok;
    logic [7:0] hours_n, minutes_n, seconds_n;

    assign is_digit  = (rx_byte_r >= 8'h30) && (rx_byte_r <= 8'h39);
    assign hours_n   = {dig[0], dig[1]};
    assign minutes_n = {dig[2], dig[3]};
    assign seconds_n = {dig[4], dig[5]};
    // Digits are already 0..9, so packed BCD compares correctly as plain binary.
    assign range_ok  = (hours_n <= 8'h23) && (minutes_n <= 8'h59) && (seconds_n <= 8'h59);

    always_comb begin
        didx = 3'd0;
        case (pos)
            4'd1:    didx = 3'd1;
            4'd3:    didx = 3'd2;
            4'd4:    didx = 3'd3;
            4'd6:    didx = 3'd4;
            4'd7:    didx = 3'd5;
            default: didx = 3'd0;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            pos       <= 4'd0;
            for (int i = 0; i < 6; i++) dig[i] <= 4'd0;
            hours_r   <= 8'h00;
            minutes_r <= 8'h00;
            seconds_r <= 8'h00;
            tv_r      <= 1'b0;
            perr_r    <= 1'b0;
        end else begin
            tv_r   <= 1'b0;
            perr_r <= 1'b0;
            if (frame_err_r) begin
                pos <= 4'd0;
            end else if (byte_vld_r) begin
                case (pos)
                    4'd0, 4'd1, 4'd3, 4'd4, 4'd6, 4'd7: begin
                        if (is_digit) begin
                            dig[didx] <= rx_byte_r[3:0];
                            pos       <= pos + 4'd1;
                        end else if (!(pos == 4'd0 && rx_byte_r == CH_LF)) begin
                            perr_r <= 1'b1;
                            pos    <= 4'd0;
                        end
                    end
                    4'd2, 4'd5: begin
                        if (rx_byte_r == CH_COLON) begin
                            pos <= pos + 4'd1;
                        end else begin
                            perr_r <= 1'b1;
                            pos    <= 4'd0;
                        end
                    end
                    4'd8: begin
                        if (rx_byte_r == CH_CR && range_ok) begin
                            hours_r   <= hours_n;
                            minutes_r <= minutes_n;
                            seconds_r <= seconds_n;
                            tv_r      <= 1'b1;
                        end else begin
                            perr_r <= 1'b1;
                        end
                        pos <= 4'd0;
                    end
                    default: pos <= 4'd0;
                endcase
            end
        end
    end

    assign io.rx_byte       = rx_byte_r;
    assign io.rx_byte_valid = byte_vld_r;
    assign io.frame_err     = frame_err_r;
    assign io.hours         = hours_r;
    assign io.minutes       = minutes_r;
    assign io.seconds       = seconds_r;
    assign io.time_valid    = tv_r;
    assign io.parse_err     = perr_r;
    assign io.rx_state      = state;

`ifdef UART_TIME_RX_SEG_EN
    // Active-low a..g in bits 0..6, decimal point held off.
    function automatic logic [7:0] seg_enc(input logic [3:0] d);
        logic [6:0] on;
        case (d)
            4'd0:    on = 7'h3F;
            4'd1:    on = 7'h06;
            4'd2:    on = 7'h5B;
            4'd3:    on = 7'h4F;
            4'd4:    on = 7'h66;
            4'd5:    on = 7'h6D;
            4'd6:    on = 7'h7D;
            4'd7:    on = 7'h07;
            4'd8:    on = 7'h7F;
            4'd9:    on = 7'h6F;
            default: on = 7'h00;
        endcase
        return {1'b1, ~on};
    endfunction

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            segment1_export <= 8'hC0;
            segment2_export <= 8'hC0;
            segment3_export <= 8'hC0;
            segment4_export <= 8'hC0;
            segment5_export <= 8'hC0;
            segment6_export <= 8'hC0;
        end else begin
            segment1_export <= seg_enc(seconds_r[3:0]);
            segment2_export <= seg_enc(seconds_r[7:4]);
            segment3_export <= seg_enc(minutes_r[3:0]);
            segment4_export <= seg_enc(minutes_r[7:4]);
            segment5_export <= seg_enc(hours_r[3:0]);
            segment6_export <= seg_enc(hours_r[7:4]);
        end
    end
`endif

endmodule

// File: tb/tb_uart_time_rx.sv
// Bench for uart_time_rx: serial driver, byte/time scoreboard and a line-level
// reference model. Segment checks are active when UART_TIME_RX_SEG_EN is defined.
module tb_uart_time_rx;
  localparam int CLK_HZ = 1600000;
  localparam int BAUD   = 100000;
  localparam int C      = CLK_HZ / BAUD;
  // drive of start bit (at a falling edge) -> pulse visible at a falling edge
  localparam int LAT    = 3 + C / 2 + 9 * C;

  logic clk = 1'b0;
  logic rst = 1'b1;
  uart_time_rx_if bus();

`ifdef UART_TIME_RX_SEG_EN
  logic [7:0] seg1, seg2, seg3, seg4, seg5, seg6;
`endif

  uart_time_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .io          (bus)
`ifdef UART_TIME_RX_SEG_EN
    ,
    .segment1_export (seg1),
    .segment2_export (seg2),
    .segment3_export (seg3),
    .segment4_export (seg4),
    .segment5_export (seg5),
    .segment6_export (seg6)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // scoreboard
  logic [7:0]  exp_q[$];
  int          exp_cyc_q[$];
  int          ferr_cyc_q[$];
  logic [23:0] exp_t_q[$];
  int exp_perr = 0;
  int perr_cnt = 0;
  int tv_stray = 0;
  int pulse_cnt = 0;
  int last_bv_cyc = -10;
  bit sb_on = 1'b1;
  int errors = 0;
  int checks = 0;

  function automatic logic [7:0] bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic bit line_ok(input int hh, input int mm, input int ss);
    return (hh <= 23) && (mm <= 59) && (ss <= 59);
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rx_byte_valid || bus.frame_err || bus.time_valid || bus.parse_err) pulse_cnt++;
      if (sb_on) begin
        if (bus.rx_byte_valid || bus.frame_err) begin
          checks++;
          if (bus.rx_byte_valid && bus.frame_err) begin
            errors++; $display("FAIL rx_excl: rx_byte_valid and frame_err both high at cycle %0d", cyc);
          end
        end
        if (bus.time_valid || bus.parse_err) begin
          checks++;
          if (bus.time_valid && bus.parse_err) begin
            errors++; $display("FAIL parse_excl: time_valid and parse_err both high at cycle %0d", cyc);
          end
          checks++;
          if (cyc !== last_bv_cyc + 1) begin
            errors++; $display("FAIL parse_lat: result at cycle %0d, expected %0d", cyc, last_bv_cyc + 1);
          end
        end
        if (bus.time_valid) begin
          checks++;
          if (exp_t_q.size() == 0) begin
            errors++; $display("FAIL stray_time: got %h%h%h, expected none", bus.hours, bus.minutes, bus.seconds);
          end else begin
            logic [23:0] t;
            t = exp_t_q.pop_front();
            if ({bus.hours, bus.minutes, bus.seconds} !== t) begin
              errors++; $display("FAIL time: got %h%h%h, expected %h", bus.hours, bus.minutes, bus.seconds, t);
            end
          end
        end
        if (bus.parse_err) perr_cnt++;
        if (bus.rx_byte_valid) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++; $display("FAIL stray_byte: got %h, expected none", bus.rx_byte);
          end else begin
            logic [7:0] b;
            int c;
            b = exp_q.pop_front();
            c = exp_cyc_q.pop_front();
            if (bus.rx_byte !== b) begin
              errors++; $display("FAIL rx_byte: got %h, expected %h", bus.rx_byte, b);
            end
            checks++;
            if (cyc !== c) begin
              errors++; $display("FAIL rx_lat: byte at cycle %0d, expected %0d", cyc, c);
            end
          end
        end
        if (bus.frame_err) begin
          checks++;
          if (ferr_cyc_q.size() == 0) begin
            errors++; $display("FAIL stray_frame_err: at cycle %0d, expected none", cyc);
          end else begin
            int c;
            c = ferr_cyc_q.pop_front();
            if (cyc !== c) begin
              errors++; $display("FAIL frame_lat: at cycle %0d, expected %0d", cyc, c);
            end
          end
        end
      end else if (bus.time_valid) begin
        tv_stray++;
      end
      if (bus.rx_byte_valid) last_bv_cyc = cyc;
    end
  end

`ifdef UART_TIME_RX_SEG_EN
  function automatic logic [7:0] seg_model(input logic [3:0] d);
    logic [6:0] lit;
    case (d)
      4'd0: lit = 7'b0111111;
      4'd1: lit = 7'b0000110;
      4'd2: lit = 7'b1011011;
      4'd3: lit = 7'b1001111;
      4'd4: lit = 7'b1100110;
      4'd5: lit = 7'b1101101;
      4'd6: lit = 7'b1111101;
      4'd7: lit = 7'b0000111;
      4'd8: lit = 7'b1111111;
      default: lit = 7'b1101111;
    endcase
    return {1'b1, ~lit};
  endfunction

  bit seg_due = 1'b0;
  logic [23:0] seg_t;
  always @(negedge clk) begin
    if (seg_due && !rst) begin
      checks++;
      if ({seg6, seg5, seg4, seg3, seg2, seg1} !==
          {seg_model(seg_t[23:20]), seg_model(seg_t[19:16]), seg_model(seg_t[15:12]),
           seg_model(seg_t[11:8]), seg_model(seg_t[7:4]), seg_model(seg_t[3:0])}) begin
        errors++; $display("FAIL segments: got %h %h %h %h %h %h for time %h", seg6, seg5, seg4, seg3, seg2, seg1, seg_t);
      end
    end
    seg_due = bus.time_valid && !rst;
    seg_t   = {bus.hours, bus.minutes, bus.seconds};
  end
`endif

  // driver tasks (called at a falling edge, return at a falling edge)
  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    if (stop_ok) begin
      exp_q.push_back(b);
      exp_cyc_q.push_back(cyc + LAT);
    end else begin
      ferr_cyc_q.push_back(cyc + LAT);
    end
    bus.uart_rxd = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.uart_rxd = b[i];
      repeat (C) @(negedge clk);
    end
    bus.uart_rxd = stop_ok;
    repeat (C) @(negedge clk);
    bus.uart_rxd = 1'b1;
  endtask

  task automatic send_line(input string s, input bit add_cr);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    if (add_cr) send_byte(8'h0D, 1'b1);
  endtask

  task automatic send_time(input int hh, input int mm, input int ss);
    send_line($sformatf("%02d:%02d:%02d", hh, mm, ss), 1'b1);
  endtask

  task automatic expect_time(input int hh, input int mm, input int ss);
    if (line_ok(hh, mm, ss)) exp_t_q.push_back({bcd(hh), bcd(mm), bcd(ss)});
    else exp_perr++;
  endtask

  task automatic settle();
    repeat (3 * C) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.uart_rxd = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.rx_byte, bus.hours, bus.minutes, bus.seconds} !== 32'h0) begin
      errors++; $display("FAIL reset_values: got %h %h %h %h, expected 00 00 00 00", bus.rx_byte, bus.hours, bus.minutes, bus.seconds);
    end
    checks++;
    if ({bus.rx_byte_valid, bus.time_valid, bus.frame_err, bus.parse_err} !== 4'b0) begin
      errors++; $display("FAIL reset_pulses: got %b, expected 0000", {bus.rx_byte_valid, bus.time_valid, bus.frame_err, bus.parse_err});
    end
`ifdef UART_TIME_RX_SEG_EN
    checks++;
    if ({seg6, seg5, seg4, seg3, seg2, seg1} !== {6{8'hC0}}) begin
      errors++; $display("FAIL reset_segments: got %h %h %h %h %h %h, expected all c0", seg6, seg5, seg4, seg3, seg2, seg1);
    end
`endif
  endtask

  task automatic test_basic_line();
    expect_time(12, 34, 56);
    send_time(12, 34, 56);
    settle();
    checks++;
    if ({bus.hours, bus.minutes, bus.seconds} !== 24'h123456) begin
      errors++; $display("FAIL basic_hold: got %h%h%h, expected 123456", bus.hours, bus.minutes, bus.seconds);
    end
`ifdef UART_TIME_RX_SEG_EN
    checks++;
    if (seg1 !== 8'h82 || seg6 !== 8'hF9) begin
      errors++; $display("FAIL basic_segments: got seg1=%h seg6=%h, expected 82 f9", seg1, seg6);
    end
`endif
    checks++;
    if (exp_q.size() + exp_t_q.size() != 0 || perr_cnt != exp_perr) begin
      errors++; $display("FAIL basic_sb: pending=%0d perr=%0d, expected 0 and %0d", exp_q.size() + exp_t_q.size(), perr_cnt, exp_perr);
    end
  endtask

  task automatic test_range_err();
    expect_time(24, 0, 0);
    send_time(24, 0, 0);
    expect_time(12, 60, 0);
    send_time(12, 60, 0);
    expect_time(9, 5, 60);
    send_time(9, 5, 60);
    settle();
    checks++;
    if ({bus.hours, bus.minutes, bus.seconds} !== 24'h123456) begin
      errors++; $display("FAIL range_hold: got %h%h%h, expected 123456", bus.hours, bus.minutes, bus.seconds);
    end
    checks++;
    if (perr_cnt != exp_perr || exp_t_q.size() != 0) begin
      errors++; $display("FAIL range_sb: perr=%0d pending=%0d, expected %0d and 0", perr_cnt, exp_t_q.size(), exp_perr);
    end
  endtask

  task automatic test_malformed();
    // "12" then early CR: one error, CR not restarted as a line
    send_line("12", 1'b1);
    exp_perr += 1;
    // digit expected, ':' found; then "2" and CR early: two errors
    send_line("1:2", 1'b1);
    exp_perr += 2;
    // LF in mid-line
    send_line("1", 1'b0);
    send_byte(8'h0A, 1'b1);
    exp_perr += 1;
    expect_time(20, 15, 45);
    send_time(20, 15, 45);
    settle();
    checks++;
    if (perr_cnt != exp_perr || exp_t_q.size() != 0) begin
      errors++; $display("FAIL malformed_sb: perr=%0d pending=%0d, expected %0d and 0", perr_cnt, exp_t_q.size(), exp_perr);
    end
  endtask

  task automatic test_frame_err();
    send_byte(8'h31, 1'b1);
    send_byte(8'h31, 1'b0);
    bus.uart_rxd = 1'b0;
    repeat (2 * C) @(negedge clk);
    bus.uart_rxd = 1'b1;
    repeat (2 * C) @(negedge clk);
    expect_time(7, 8, 9);
    send_time(7, 8, 9);
    settle();
    checks++;
    if ({bus.hours, bus.minutes, bus.seconds} !== 24'h070809) begin
      errors++; $display("FAIL frame_recover: got %h%h%h, expected 070809", bus.hours, bus.minutes, bus.seconds);
    end
    checks++;
    if (ferr_cyc_q.size() != 0 || exp_q.size() != 0 || perr_cnt != exp_perr) begin
      errors++; $display("FAIL frame_sb: ferr_pending=%0d byte_pending=%0d perr=%0d, expected 0 0 %0d", ferr_cyc_q.size(), exp_q.size(), perr_cnt, exp_perr);
    end
  endtask

  task automatic test_glitch();
    int p0;
    p0 = pulse_cnt;
    bus.uart_rxd = 1'b0;
    repeat (C / 2 - 3) @(negedge clk);
    bus.uart_rxd = 1'b1;
    repeat (20 * C) @(negedge clk);
    checks++;
    if (pulse_cnt != p0) begin
      errors++; $display("FAIL glitch: %0d pulses, expected 0", pulse_cnt - p0);
    end
    expect_time(10, 20, 30);
    send_time(10, 20, 30);
    settle();
    checks++;
    if (exp_t_q.size() != 0 || {bus.hours, bus.minutes, bus.seconds} !== 24'h102030) begin
      errors++; $display("FAIL glitch_line: got %h%h%h, expected 102030", bus.hours, bus.minutes, bus.seconds);
    end
  endtask

  task automatic test_reset_mid_line();
    send_line("12:", 1'b0);
    settle();
    sb_on = 1'b0;
    tv_stray = 0;
    fork
      send_line("34:56", 1'b1);
      begin
        repeat (C + 3 * C + C / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({bus.rx_byte, bus.hours, bus.minutes, bus.seconds} !== 32'h0 ||
            {bus.rx_byte_valid, bus.time_valid, bus.frame_err, bus.parse_err} !== 4'b0) begin
          errors++; $display("FAIL midreset_values: got %h %h %h %h pulses=%b, expected zeros", bus.rx_byte, bus.hours, bus.minutes, bus.seconds,
                             {bus.rx_byte_valid, bus.time_valid, bus.frame_err, bus.parse_err});
        end
      end
    join
    repeat (12 * C) @(negedge clk);
    checks++;
    if (tv_stray != 0) begin
      errors++; $display("FAIL midreset_stray: %0d time_valid pulses, expected 0", tv_stray);
    end
    exp_q.delete();
    exp_cyc_q.delete();
    ferr_cyc_q.delete();
    exp_t_q.delete();
    perr_cnt = 0;
    exp_perr = 0;
    sb_on = 1'b1;
    send_byte(8'h0D, 1'b1);
    exp_perr += 1;
    expect_time(21, 43, 5);
    send_time(21, 43, 5);
    settle();
    checks++;
    if ({bus.hours, bus.minutes, bus.seconds} !== 24'h214305 || perr_cnt != exp_perr) begin
      errors++; $display("FAIL midreset_next: got %h%h%h perr=%0d, expected 214305 perr=%0d", bus.hours, bus.minutes, bus.seconds, perr_cnt, exp_perr);
    end
  endtask

  task automatic test_back_to_back();
    expect_time(23, 59, 59);
    expect_time(0, 0, 0);
    send_byte(8'h0A, 1'b1);
    send_time(23, 59, 59);
    send_byte(8'h0A, 1'b1);
    send_time(0, 0, 0);
    settle();
    checks++;
    if (exp_t_q.size() != 0 || exp_q.size() != 0 || {bus.hours, bus.minutes, bus.seconds} !== 24'h000000) begin
      errors++; $display("FAIL b2b: pending=%0d got %h%h%h, expected 0 and 000000", exp_t_q.size() + exp_q.size(), bus.hours, bus.minutes, bus.seconds);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      int hh, mm, ss;
      hh = $urandom_range(29, 0);
      mm = $urandom_range(69, 0);
      ss = $urandom_range(69, 0);
      if ($urandom_range(1, 0) == 1) send_byte(8'h0A, 1'b1);
      expect_time(hh, mm, ss);
      send_time(hh, mm, ss);
    end
    settle();
    checks++;
    if (exp_t_q.size() != 0 || exp_q.size() != 0 || perr_cnt != exp_perr) begin
      errors++; $display("FAIL random_sb: pending=%0d perr=%0d, expected 0 and %0d", exp_t_q.size() + exp_q.size(), perr_cnt, exp_perr);
    end
  endtask

  initial begin
    bus.uart_rxd = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic_line();
    test_range_err();
    test_malformed();
    test_frame_err();
    test_glitch();
    test_reset_mid_line();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
